// File: rtl/posit_decode_seq_if.sv
// posit_decode_seq_if: bundles the posit decoder's input handshake, output
// handshake and decoded field outputs.
//   slave  - decoder side (consumes posit words, produces fields)
//   master - environment side (drives posit words, consumes fields)
// Optional total exponent output present when POSIT_DEC_TOTAL_EO_EN is defined.
interface posit_decode_seq_if #(
  parameter int N  = 8,
  parameter int ES = 4
);
  localparam int RS = $clog2(N);
  localparam int MW = N - ES - 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [N-1:0]         posit_in;
  logic                 out_valid;
  logic                 out_ready;
  logic                 sign_o;
  logic signed [RS:0]   regime_o;
  logic [ES-1:0]        exp_o;
  logic [MW-1:0]        mant_o;
  logic                 inf_o;
  logic                 zero_o;
`ifdef POSIT_DEC_TOTAL_EO_EN
  logic signed [RS+ES:0] total_eo_o;
`endif

  modport slave (
    input  in_valid,
    output in_ready,
    input  posit_in,
    output out_valid,
    input  out_ready,
    output sign_o,
    output regime_o,
    output exp_o,
    output mant_o,
    output inf_o,
`ifdef POSIT_DEC_TOTAL_EO_EN
    output total_eo_o,
`endif
    output zero_o
  );

  modport master (
    output in_valid,
    input  in_ready,
    output posit_in,
    input  out_valid,
    output out_ready,
    input  sign_o,
    input  regime_o,
    input  exp_o,
    input  mant_o,
    input  inf_o,
`ifdef POSIT_DEC_TOTAL_EO_EN
    input  total_eo_o,
`endif
    input  zero_o
  );
endinterface

// File: rtl/posit_decode_seq.sv
// posit_decode_seq: sequential posit field extractor.
// Accepts an N-bit posit word, counts the regime run one bit per clock and
// presents sign, signed regime, exponent, mantissa (with hidden bit) and
// zero/NaR flags behind a valid/ready handshake.
// Optional feature macro: POSIT_DEC_TOTAL_EO_EN adds total_eo_o = {regime, exp}.
module posit_decode_seq #(
  parameter int N  = 8,
  parameter int ES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  posit_decode_seq_if.slave    bus
);
  localparam int RS = $clog2(N);
  localparam int MW = N - ES - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_reg;
  logic                 in_ready_reg;
  logic                 out_valid_reg;

  // Working registers for the regime scan.
  logic                 sign_reg;
  logic                 rbit_reg;
  logic [N-2:0]         shift_reg;
  logic [RS-1:0]        count_reg;

  // Registered field outputs, updated only on entry to DONE.
  logic                 sign_o_reg;
  logic signed [RS:0]   regime_o_reg;
  logic [ES-1:0]        exp_o_reg;
  logic [MW-1:0]        mant_o_reg;
  logic                 inf_o_reg;
  logic                 zero_o_reg;
`ifdef POSIT_DEC_TOTAL_EO_EN
  logic signed [RS+ES:0] total_eo_o_reg;
`endif

  // Input classification and magnitude. Only the low N-1 bits of the
  // magnitude are needed: the top bit of |x| is 0 for every non-special word.
  logic                 in_is_zero;
  logic                 in_is_nar;
  logic [N-2:0]         abs_low;

  assign in_is_zero = (bus.posit_in == '0);
  assign in_is_nar  = (bus.posit_in == {1'b1, {(N-1){1'b0}}});
  assign abs_low    = bus.posit_in[N-1] ? (~bus.posit_in[N-2:0] + (N-1)'(1))
                                        : bus.posit_in[N-2:0];

  // Regime scan step decision: keep counting while the run continues and
  // the run has not consumed every bit below the sign.
  logic                 count_below_max;
  logic                 run_continue;

  assign count_below_max = (count_reg < RS'(N - 1));
  assign run_continue    = (shift_reg[N-2] == rbit_reg) && count_below_max;

  // Signed regime: a run of ones of length k means k-1, zeros mean -k.
  logic [RS:0]          count_ext;
  logic signed [RS:0]   regime_w;

  assign count_ext = {1'b0, count_reg};
  assign regime_w  = rbit_reg ? (count_ext - (RS+1)'(1)) : (-count_ext);

  // Bits after the terminator, MSB-aligned at N-2. Bit 0 of the shifted
  // value is always a fill zero and never feeds a field, so it is dropped.
  logic [N-2:1]         rest_w;

  assign rest_w = count_below_max ? shift_reg[N-3:0] : '0;

  // Exponent taps: the ES bits following the terminator; taps that would
  // fall below the word read as zero.
  logic [ES-1:0]        exp_w;

  generate
    for (genvar gi = 0; gi < ES; gi++) begin : g_exp_tap
      if (N - 2 - gi >= 1) begin : g_present
        assign exp_w[ES-1-gi] = rest_w[N-2-gi];
      end else begin : g_missing
        assign exp_w[ES-1-gi] = 1'b0;
      end
    end
  endgenerate

  // Mantissa: hidden one followed by the fraction bits that follow the
  // exponent, left-aligned.
  logic [MW-1:0]        mant_w;

  assign mant_w[MW-1] = 1'b1;

  generate
    for (genvar gi = 0; gi < MW - 1; gi++) begin : g_frac_tap
      if (N - 2 - ES - gi >= 1) begin : g_present
        assign mant_w[MW-2-gi] = rest_w[N-2-ES-gi];
      end else begin : g_missing
        assign mant_w[MW-2-gi] = 1'b0;
      end
    end
  endgenerate

`ifdef POSIT_DEC_TOTAL_EO_EN
  // Combined scale: regime * 2^ES + exponent is just the concatenation.
  logic signed [RS+ES:0] total_eo_w;

  assign total_eo_w = {regime_w, exp_w};
`endif

  // Control FSM with registered handshake outputs and field capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      sign_reg       <= 1'b0;
      rbit_reg       <= 1'b0;
      shift_reg      <= '0;
      count_reg      <= '0;
      sign_o_reg     <= 1'b0;
      regime_o_reg   <= '0;
      exp_o_reg      <= '0;
      mant_o_reg     <= '0;
      inf_o_reg      <= 1'b0;
      zero_o_reg     <= 1'b0;
`ifdef POSIT_DEC_TOTAL_EO_EN
      total_eo_o_reg <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            sign_reg     <= bus.posit_in[N-1];
            in_ready_reg <= 1'b0;
            if (in_is_zero || in_is_nar) begin
              // Specials bypass the scan and are emitted next cycle.
              sign_o_reg     <= bus.posit_in[N-1];
              regime_o_reg   <= '0;
              exp_o_reg      <= '0;
              mant_o_reg     <= '0;
              inf_o_reg      <= in_is_nar;
              zero_o_reg     <= in_is_zero;
`ifdef POSIT_DEC_TOTAL_EO_EN
              total_eo_o_reg <= '0;
`endif
              out_valid_reg  <= 1'b1;
              state_reg      <= DONE;
            end else begin
              shift_reg <= abs_low;
              rbit_reg  <= abs_low[N-2];
              count_reg <= '0;
              state_reg <= COUNT;
            end
          end
        end

        COUNT: begin
          if (run_continue) begin
            count_reg <= count_reg + RS'(1);
            shift_reg <= {shift_reg[N-3:0], 1'b0};
          end else begin
            sign_o_reg     <= sign_reg;
            regime_o_reg   <= regime_w;
            exp_o_reg      <= exp_w;
            mant_o_reg     <= mant_w;
            inf_o_reg      <= 1'b0;
            zero_o_reg     <= 1'b0;
`ifdef POSIT_DEC_TOTAL_EO_EN
            total_eo_o_reg <= total_eo_w;
`endif
            out_valid_reg  <= 1'b1;
            state_reg      <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.sign_o     = sign_o_reg;
  assign bus.regime_o   = regime_o_reg;
  assign bus.exp_o      = exp_o_reg;
  assign bus.mant_o     = mant_o_reg;
  assign bus.inf_o      = inf_o_reg;
  assign bus.zero_o     = zero_o_reg;
`ifdef POSIT_DEC_TOTAL_EO_EN
  assign bus.total_eo_o = total_eo_o_reg;
`endif

endmodule

// File: tb/tb_posit_decode_seq.sv
// tb_posit_decode_seq: directed + random self-checking bench for the
// sequential posit decoder (N=8, ES=4). Expected results are pushed to a
// scoreboard queue when a word is driven and popped when out_valid rises.
module tb_posit_decode_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  posit_decode_seq_if #(.N(8), .ES(4)) bus ();

  posit_decode_seq #(.N(8), .ES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]         word;
    logic               sign;
    logic signed [3:0]  regime;
    logic [3:0]         exp;
    logic [2:0]         mant;
    logic               inf;
    logic               zero;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation builder for the directed vectors.
  function automatic exp_t lit(input logic [7:0] w, input logic s, input int rg,
                               input logic [3:0] e, input logic [2:0] m,
                               input logic inf, input logic zero, input int lat);
    exp_t r;
    r.word = w; r.sign = s; r.regime = 4'(rg); r.exp = e; r.mant = m;
    r.inf = inf; r.zero = zero; r.lat = lat;
    return r;
  endfunction

  // Reference decode: measure the run length directly on the magnitude.
  function automatic exp_t model(input logic [7:0] p);
    exp_t r;
    logic [7:0] a;
    logic [6:0] bits;
    logic [6:0] rem;
    logic       rb;
    int         k;
    int         rg;
    r.word = p; r.sign = p[7]; r.regime = '0; r.exp = '0; r.mant = '0;
    r.inf = (p == 8'h80); r.zero = (p == 8'h00); r.lat = 1;
    if (!r.inf && !r.zero) begin
      a = p[7] ? (~p + 8'd1) : p;
      bits = a[6:0];
      rb = bits[6];
      k = 0;
      while (k < 7 && bits[6-k] == rb) k++;
      rg = rb ? k - 1 : -k;
      r.regime = 4'(rg);
      rem = 7'(bits << (k + 1));
      r.exp = rem[6:3];
      r.mant = {1'b1, rem[2:1]};
      r.lat = k + 1;
    end
    return r;
  endfunction

  task automatic check_fields(input exp_t e, input string pre);
    check($sformatf("%s_sign_%h", pre, e.word), bus.sign_o, e.sign);
    check($sformatf("%s_regime_%h", pre, e.word), bus.regime_o, e.regime);
    check($sformatf("%s_exp_%h", pre, e.word), bus.exp_o, e.exp);
    check($sformatf("%s_mant_%h", pre, e.word), bus.mant_o, e.mant);
    check($sformatf("%s_inf_%h", pre, e.word), bus.inf_o, e.inf);
    check($sformatf("%s_zero_%h", pre, e.word), bus.zero_o, e.zero);
`ifdef POSIT_DEC_TOTAL_EO_EN
    check($sformatf("%s_total_eo_%h", pre, e.word), bus.total_eo_o,
          $signed({e.regime, e.exp}));
`endif
  endtask

  // Present a word until in_ready, let it be accepted, optionally scoreboard it.
  task automatic accept(input logic [7:0] w, input bit push, input exp_t e);
    int waitc = 0;
    while (!bus.in_ready && waitc < 50) begin
      tick();
      waitc++;
    end
    check($sformatf("in_ready_before_%h", w), bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.posit_in = w;
    if (push) sb.push_back(e);
    tick();
    bus.in_valid = 1'b0;
    check($sformatf("in_ready_after_accept_%h", w), bus.in_ready, 0);
  endtask

  // Called right after the acceptance edge; measures latency and checks fields.
  task automatic wait_and_check();
    int lat = 0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=0 required=1");
      return;
    end
    cur = sb.pop_front();
    do begin
      tick();
      lat++;
    end while (!bus.out_valid && lat < 40);
    check($sformatf("latency_%h", cur.word), 32'(lat), 32'(cur.lat));
    check($sformatf("in_ready_in_done_%h", cur.word), bus.in_ready, 0);
    check_fields(cur, "out");
    $display("word=%h sign=%0b regime=%0d exp=%h mant=%b inf=%0b zero=%0b latency=%0d",
             cur.word, bus.sign_o, bus.regime_o, bus.exp_o, bus.mant_o,
             bus.inf_o, bus.zero_o, lat);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check($sformatf("out_valid_drop_%h", cur.word), bus.out_valid, 0);
    check($sformatf("in_ready_back_%h", cur.word), bus.in_ready, 1);
  endtask

  initial begin
    exp_t dirs[7];
    exp_t dummy;
    bit   seen;
    logic [7:0] rw;

    dirs[0] = lit(8'h40, 1'b0,  0, 4'h0, 3'b100, 1'b0, 1'b0, 2);
    dirs[1] = lit(8'h4B, 1'b0,  0, 4'h5, 3'b110, 1'b0, 1'b0, 2);
    dirs[2] = lit(8'hC0, 1'b1,  0, 4'h0, 3'b100, 1'b0, 1'b0, 2);
    dirs[3] = lit(8'h7F, 1'b0,  6, 4'h0, 3'b100, 1'b0, 1'b0, 8);
    dirs[4] = lit(8'h01, 1'b0, -6, 4'h0, 3'b100, 1'b0, 1'b0, 7);
    dirs[5] = lit(8'h00, 1'b0,  0, 4'h0, 3'b000, 1'b0, 1'b1, 1);
    dirs[6] = lit(8'h80, 1'b1,  0, 4'h0, 3'b000, 1'b1, 1'b0, 1);
    dummy   = lit(8'h00, 1'b0,  0, 4'h0, 3'b000, 1'b0, 1'b0, 0);

    // Reset held two cycles with a valid word presented.
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.posit_in = 8'h4B;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check_fields(dummy, "reset");
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    check("post_reset_out_valid", bus.out_valid, 0);

    // Reset while in COUNT aborts the word.
    accept(8'h7F, 1'b0, dummy);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_output", seen, 0);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      accept(dirs[i].word, 1'b1, dirs[i]);
      wait_and_check();
      handshake();
    end

    // Backpressure with a competing word held on the input.
    accept(8'h01, 1'b1, dirs[4]);
    wait_and_check();
    bus.in_valid = 1'b1;
    bus.posit_in = 8'h4B;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_out_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("hold_in_ready_%0d", i), bus.in_ready, 0);
      check_fields(cur, "hold");
    end
    sb.push_back(dirs[1]);
    handshake();
    tick();
    bus.in_valid = 1'b0;
    check("next_accept_in_ready", bus.in_ready, 0);
    wait_and_check();
    handshake();

    // Random words against the reference model.
    for (int i = 0; i < 12; i++) begin
      rw = 8'($urandom_range(0, 255));
      accept(rw, 1'b1, model(rw));
      wait_and_check();
      handshake();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
